// File: rtl/dp_int_to_fp_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dp_int_to_fp_seq                                             |
// | Description : Multi-cycle integer to binary64 converter (FCVT.D.W/WU/L/LU) |
// |               with IEEE-754 rounding and inexact flag. Valid/ready on both |
// |               sides, one conversion in flight.                             |
// |               Build option DP_I2F_FAST_NORM_EN: single-cycle normalisation |
// |               via a 64-bit leading-zero count and barrel shift. Otherwise  |
// |               normalisation shifts one bit per cycle.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dp_int_to_fp_seq #(
  parameter int BIAS  = 1023,
  parameter int INT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] int_in,
  input  logic [1:0]       cvt_type,
  input  logic [2:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      fp_out,
  output logic             flag_inexact
);

  // Exponent of a magnitude whose top bit is already set.
  localparam logic [10:0] c_exp_top = 11'(BIAS + INT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_sign;
  logic [INT_W-1:0]  r_mag;
  logic [10:0]       r_exp;
  logic [2:0]        r_rm;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [63:0]       r_fp_out;
  logic              r_inexact;

  logic [INT_W-1:0]  w_ext;
  logic              w_neg;
  logic [INT_W-1:0]  w_abs;
  logic [51:0]       w_frac;
  logic              w_guard;
  logic              w_sticky;
  logic              w_nx;
  logic              w_inc;
  logic [52:0]       w_frac_sum;
  logic [10:0]       w_exp_rnd;

  // Operand extension and absolute value; bit1 of cvt_type selects 64-bit, bit0 unsigned.
  always_comb begin
    w_ext = '0;
    if (cvt_type[1])
      w_ext = int_in;
    else if (cvt_type[0])
      w_ext = {32'b0, int_in[31:0]};
    else
      w_ext = {{32{int_in[31]}}, int_in[31:0]};
    w_neg = ~cvt_type[0] & w_ext[INT_W-1];
    // -2^63 negates to itself, which is the correct unsigned magnitude.
    w_abs = w_neg ? (~w_ext + 1'b1) : w_ext;
  end

  // Rounding of the normalised magnitude to a 52-bit fraction.
  always_comb begin
    w_frac   = r_mag[62:11];
    w_guard  = r_mag[10];
    w_sticky = |r_mag[9:0];
    w_nx     = w_guard | w_sticky;
    case (r_rm)
      3'b001:  w_inc = 1'b0;                        // RTZ
      3'b010:  w_inc = r_sign & w_nx;               // RDN
      3'b011:  w_inc = ~r_sign & w_nx;              // RUP
      3'b100:  w_inc = w_guard;                     // RMM
      default: w_inc = w_guard & (w_sticky | w_frac[0]); // RNE
    endcase
    w_frac_sum = {1'b0, w_frac} + {52'b0, w_inc};
    // A fraction carry-out means the mantissa became 2.0: exponent steps up, fraction wraps to 0.
    w_exp_rnd  = w_frac_sum[52] ? (r_exp + 11'd1) : r_exp;
  end

`ifdef DP_I2F_FAST_NORM_EN
  logic [5:0] w_lz;

  // Leading-zero count of the latched magnitude; highest set bit wins.
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (r_mag[i])
        w_lz = 6'(INT_W - 1 - i);
    end
  end
`endif

  // Conversion sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_exp       <= '0;
      r_rm        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_fp_out    <= '0;
      r_inexact   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign     <= w_neg;
            r_mag      <= w_abs;
            r_exp      <= c_exp_top;
            r_rm       <= rm;
            r_in_ready <= 1'b0;
            if (w_abs == '0) begin
              // Zero converts to +0 exactly, regardless of type and rounding mode.
              r_fp_out    <= '0;
              r_inexact   <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_NORM;
            end
          end
        end
        S_NORM: begin
`ifdef DP_I2F_FAST_NORM_EN
          r_mag   <= r_mag << w_lz;
          r_exp   <= r_exp - {5'b0, w_lz};
          r_state <= S_ROUND;
`else
          if (r_mag[INT_W-1]) begin
            r_state <= S_ROUND;
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 11'd1;
          end
`endif
        end
        S_ROUND: begin
          r_fp_out    <= {r_sign, w_exp_rnd, w_frac_sum[51:0]};
          r_inexact   <= w_nx;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign fp_out       = r_fp_out;
  assign flag_inexact = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_dp_int_to_fp_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dp_int_to_fp_seq                                          |
// | Description : Directed-vector bench for dp_int_to_fp_seq with hand-derived |
// |               binary64 results, flags and latencies.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dp_int_to_fp_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] int_in;
  logic [1:0]  cvt_type;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] fp_out;
  logic        flag_inexact;

  int n_vec;
  int n_err;

  dp_int_to_fp_seq #(.BIAS(1023), .INT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .int_in       (int_in),
    .cvt_type     (cvt_type),
    .rm           (rm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fp_out       (fp_out),
    .flag_inexact (flag_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One conversion: present at a negedge, accept at E0, wait for result,
  // optionally hold out_ready low for 'hold' cycles while noise is driven, then hand off.
  task automatic do_conv(input string tag, input logic [1:0] t, input logic [63:0] v,
                         input logic [2:0] m, input logic [63:0] exp_fp, input logic exp_nx,
                         input int lz, input bit is_zero, input int hold);
    int cyc;
    int exp_lat;
    if (is_zero)
      exp_lat = 1;
    else begin
`ifdef DP_I2F_FAST_NORM_EN
      exp_lat = 2;
`else
      exp_lat = lz + 2;
`endif
    end
    @(negedge clk);
    cvt_type = t;
    int_in   = v;
    rm       = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    int_in   = ~v;
    rm       = 3'b011;
    cvt_type = ~t;
    check({tag, ":busy"}, {63'b0, in_ready}, 64'd0);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 200);
    check({tag, ":lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, ":fp"}, fp_out, exp_fp);
    check({tag, ":nx"}, {63'b0, flag_inexact}, {63'b0, exp_nx});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      int_in   = 64'h1234_5678_9ABC_DEF0 + 64'(i);
      @(posedge clk);
      #1;
      check({tag, ":hold_v"}, {63'b0, out_valid}, 64'd1);
      check({tag, ":hold_fp"}, fp_out, exp_fp);
      check({tag, ":hold_rdy"}, {63'b0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ":ret_v"}, {63'b0, out_valid}, 64'd0);
    check({tag, ":ret_rdy"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    int_in    = '0;
    cvt_type  = '0;
    rm        = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rdy", {63'b0, in_ready}, 64'd1);
    check("rst_v",   {63'b0, out_valid}, 64'd0);
    check("rst_fp",  fp_out, 64'd0);
    check("rst_nx",  {63'b0, flag_inexact}, 64'd0);

    //       tag          type   value                   rm      expected fp             nx  lz  zero hold
    do_conv("l_one",      2'b10, 64'h0000000000000001, 3'b000, 64'h3FF0000000000000, 1'b0, 63, 0, 0);
    do_conv("w_m1",       2'b00, 64'h00000000FFFFFFFF, 3'b000, 64'hBFF0000000000000, 1'b0, 63, 0, 0);
    do_conv("wu_max",     2'b01, 64'h00000000FFFFFFFF, 3'b000, 64'h41EFFFFFFFE00000, 1'b0, 32, 0, 0);
    do_conv("lu_max_rne", 2'b11, 64'hFFFFFFFFFFFFFFFF, 3'b000, 64'h43F0000000000000, 1'b1, 0,  0, 0);
    do_conv("lu_max_rtz", 2'b11, 64'hFFFFFFFFFFFFFFFF, 3'b001, 64'h43EFFFFFFFFFFFFF, 1'b1, 0,  0, 5);
    do_conv("lu_max_rm7", 2'b11, 64'hFFFFFFFFFFFFFFFF, 3'b111, 64'h43F0000000000000, 1'b1, 0,  0, 0);
    do_conv("l_min",      2'b10, 64'h8000000000000000, 3'b000, 64'hC3E0000000000000, 1'b0, 0,  0, 0);
    do_conv("tie_even",   2'b11, 64'h8000000000000400, 3'b000, 64'h43E0000000000000, 1'b1, 0,  0, 0);
    do_conv("tie_rmm",    2'b11, 64'h8000000000000400, 3'b100, 64'h43E0000000000001, 1'b1, 0,  0, 0);
    do_conv("tie_rup",    2'b11, 64'h8000000000000400, 3'b011, 64'h43E0000000000001, 1'b1, 0,  0, 0);
    do_conv("tie_rdn",    2'b11, 64'h8000000000000400, 3'b010, 64'h43E0000000000000, 1'b1, 0,  0, 0);
    do_conv("tie_odd",    2'b11, 64'h8000000000000C00, 3'b000, 64'h43E0000000000002, 1'b1, 0,  0, 0);
    do_conv("neg_rdn",    2'b10, 64'hBFFFFFFFFFFFFFFF, 3'b010, 64'hC3D0000000000001, 1'b1, 1,  0, 0);
    do_conv("neg_rup",    2'b10, 64'hBFFFFFFFFFFFFFFF, 3'b011, 64'hC3D0000000000000, 1'b1, 1,  0, 0);
    do_conv("w_hi_junk",  2'b00, 64'hDEADBEEF00000005, 3'b000, 64'h4014000000000000, 1'b0, 61, 0, 0);
    do_conv("zero_l",     2'b10, 64'h0000000000000000, 3'b011, 64'h0000000000000000, 1'b0, 0,  1, 0);
    do_conv("zero_w",     2'b00, 64'hFFFFFFFF00000000, 3'b010, 64'h0000000000000000, 1'b0, 0,  1, 0);

    // Abort a long normalisation with an asynchronous reset pulse between edges.
    @(negedge clk);
    cvt_type = 2'b10;
    int_in   = 64'd1;
    rm       = 3'b000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    check("abort_v",   {63'b0, out_valid}, 64'd0);
    check("abort_rdy", {63'b0, in_ready}, 64'd1);
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        check("abort_spurious", {63'b0, out_valid}, 64'd0);
        break;
      end
    end
    do_conv("post_abort", 2'b01, 64'h0000000000000003, 3'b000, 64'h4008000000000000, 1'b0, 62, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
